midi_note_tx: RTL

- Consumes 32-bit key events from the keyboard scanner's event stream and turns each one into a MIDI Note On or Note Off message.
- Transmits the message on a standard 31250-baud serial MIDI OUT line: 8N1, LSB first.
- Sits directly downstream of the scanner's event FIFO, fed by the firmware or a DMA/bridge over a valid/ready handshake.
- Supports MIDI running status to cut down on bytes sent.

---
 rtl/midi_note_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/midi_note_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : midi_note_tx
// Description : Turns 32-bit keyboard scanner events into MIDI Note On / Note
//               Off messages and shifts them out on a 31250-baud 8N1 MIDI OUT
//               line (LSB first). Running status can be used to omit a
//               repeated status byte.
// Revision    : 1.0 - initial release
// ============================================================================
module midi_note_tx #(
  parameter int CLK_DIV   = 800,
  parameter int BASE_NOTE = 36
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        evt_valid,
  input  logic [31:0] evt_data,
  output logic        evt_ready,
  input  logic [3:0]  channel,
  input  logic        rs_en,
  output logic        midi_tx,
  output logic        busy,
  output logic        drop
);

  localparam logic [15:0] C_DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [8:0]  C_BASE     = 9'(BASE_NOTE);

  // NEXT is not a separate state: the byte/idle decision is taken in the
  // final STOP cycle so consecutive frames abut with no gap.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [15:0]     r_div;
  logic [2:0]      r_bit;
  logic [1:0]      r_idx;
  logic [1:0]      r_last;
  logic [3:0][7:0] r_msg;
  logic            r_rs_valid;
  logic [7:0]      r_rs_status;
  logic            r_tx;
  logic            r_drop;

  logic [8:0] w_note;
  logic       w_note_ok;
  logic       w_press;
  logic [7:0] w_vel;
  logic [7:0] w_status;
  logic [7:0] w_data2;
  logic       w_skip;
  logic       w_accept;
  logic       w_div_done;
  logic [2:0] w_nbit;
  logic       w_unused;

  assign w_note     = C_BASE + {1'b0, evt_data[7:0]};
  assign w_note_ok  = (w_note <= 9'd127);
  assign w_press    = evt_data[16];
  assign w_vel      = evt_data[15:8];
  assign w_status   = {(w_press ? 4'h9 : 4'h8), channel};
  assign w_accept   = evt_valid && (r_state == S_IDLE);
  assign w_div_done = (r_div == C_DIV_LAST);
  assign w_nbit     = r_bit + 3'd1;
  assign w_skip     = rs_en && r_rs_valid && (r_rs_status == w_status);
  assign w_unused   = ^evt_data[31:17];

  // Second data byte: clamped velocity on press, fixed 0x40 on release.
  always_comb begin
    w_data2 = 8'h40;
    if (w_press) begin
      if (w_vel == 8'h00)
        w_data2 = 8'h01;
      else if (w_vel[7])
        w_data2 = 8'h7F;
      else
        w_data2 = w_vel;
    end
  end

  assign evt_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign midi_tx   = r_tx;
  assign drop      = r_drop;

  // Event accept, message latch and bit-serial frame sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_idx       <= '0;
      r_last      <= '0;
      r_msg       <= '0;
      r_rs_valid  <= 1'b0;
      r_rs_status <= '0;
      r_tx        <= 1'b1;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_note_ok) begin
              // Out-of-range note: discard, leave line and running status alone.
              r_drop <= 1'b1;
            end else begin
              if (w_skip) begin
                r_msg  <= {8'h00, 8'h00, w_data2, w_note[7:0]};
                r_last <= 2'd1;
              end else begin
                r_msg  <= {8'h00, w_data2, w_note[7:0], w_status};
                r_last <= 2'd2;
              end
              // With rs_en low the stored status is left invalid.
              r_rs_valid  <= rs_en;
              r_rs_status <= w_status;
              r_idx       <= 2'd0;
              r_div       <= '0;
              r_tx        <= 1'b0;
              r_state     <= S_START;
            end
          end
        end
        S_START: begin
          if (w_div_done) begin
            r_div   <= '0;
            r_bit   <= 3'd0;
            r_tx    <= r_msg[r_idx][0];
            r_state <= S_DATA;
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
        S_DATA: begin
          if (w_div_done) begin
            r_div <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit <= w_nbit;
              r_tx  <= r_msg[r_idx][w_nbit];
            end
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
        S_STOP: begin
          if (w_div_done) begin
            r_div <= '0;
            if (r_idx == r_last) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
